snn_spike_rate_decoder: RTL and testbench



---
 rtl/snn_pkg.sv | 16 +
 rtl/snn_sat_counter.sv | 20 ++
 rtl/snn_spike_rate_decoder.sv | 131 +++++++++++++
 tb/tb_snn_spike_rate_decoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and default sizes for the SNN spike-rate readout path.
package snn_pkg;

  localparam int DEF_N_CH  = 8;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 16;
  localparam int CH_IDX_W  = $clog2(DEF_N_CH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    HOLD  = 2'd3
  } snn_state_e;

endpackage

// File: rtl/snn_sat_counter.sv
// Per-channel spike counter: synchronous clear, increment that sticks at all-ones.
module snn_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snn_spike_rate_decoder.sv
// Counts spikes per channel over a window of enabled cycles, then scans the
// counters one per cycle for the most active channel and offers it to the host.
module snn_spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [N_CH-1:0]         spike_in,
  input  logic                    start,
  input  logic [WIN_W-1:0]        win_len,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [$clog2(N_CH)-1:0] winner,
  output logic [CNT_W-1:0]        winner_count,
  output logic                    tie,
  input  logic [$clog2(N_CH)-1:0] rd_sel,
  output logic [CNT_W-1:0]        rd_count,
  output snn_state_e              state_dbg
);

  localparam int IDX_W = $clog2(N_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  snn_state_e       state, state_next;
  logic [WIN_W-1:0] win_rem;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;
  logic             tie_r;
  logic             load_win, cnt_clr, cnt_inc_en, scan_en;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] scan_cnt;

  // Handshake: result_valid is high for the whole of HOLD; the result is taken
  // on the first clock edge where result_valid && result_ready, and
  // winner/winner_count/tie do not change while result_valid is high.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_win   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc_en = 1'b0;
    scan_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_win   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (ena) begin
          cnt_inc_en = 1'b1;
          if (win_rem == WIN_W'(1)) state_next = SCAN;
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        if (scan_idx == LAST_IDX) state_next = HOLD;
      end
      HOLD: begin
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    snn_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cnt_inc_en & spike_in[i]),
      .count (cnt[i])
    );
  end

  assign scan_cnt = cnt[scan_idx];

  // A zero window length still measures a single enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_rem  <= '0;
      scan_idx <= '0;
      best_idx <= '0;
      best_cnt <= '0;
      tie_r    <= 1'b0;
    end else begin
      if (load_win) begin
        win_rem  <= (win_len == '0) ? WIN_W'(1) : win_len;
        scan_idx <= '0;
      end else if (cnt_inc_en) begin
        win_rem <= win_rem - WIN_W'(1);
      end
      if (scan_en) begin
        scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
        if (scan_idx == '0) begin
          best_idx <= '0;
          best_cnt <= scan_cnt;
          tie_r    <= 1'b0;
        end else if (scan_cnt > best_cnt) begin
          best_idx <= scan_idx;
          best_cnt <= scan_cnt;
          tie_r    <= 1'b0;
        end else if (scan_cnt == best_cnt) begin
          tie_r <= 1'b1;
        end
      end
    end
  end

  assign busy         = (state != IDLE);
  assign result_valid = (state == HOLD);
  assign winner       = best_idx;
  assign winner_count = best_cnt;
  assign tie          = tie_r;
  assign rd_count     = cnt[rd_sel];
  assign state_dbg    = state;

endmodule

// File: tb/tb_snn_spike_rate_decoder.sv
// Bench for snn_spike_rate_decoder: directed and random windows against a
// per-channel spike-tally model with argmax computed from the final tallies.
module tb_snn_spike_rate_decoder;
  import snn_pkg::*;

  localparam int N_CH  = DEF_N_CH;
  localparam int CNT_W = DEF_CNT_W;
  localparam int WIN_W = DEF_WIN_W;
  localparam int IDX_W = CH_IDX_W;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, ena, start, result_ready;
  logic [N_CH-1:0]   spike_in;
  logic [WIN_W-1:0]  win_len;
  logic              busy, result_valid, tie;
  logic [IDX_W-1:0]  winner, rd_sel;
  logic [CNT_W-1:0]  winner_count, rd_count;
  snn_state_e        state_dbg;

  logic [CNT_W-1:0]  exp_q[$];
  int                n_vec = 0;
  int                n_err = 0;
  int                model_cnt[N_CH];

  snn_spike_rate_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .spike_in     (spike_in),
    .start        (start),
    .win_len      (win_len),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .winner       (winner),
    .winner_count (winner_count),
    .tie          (tie),
    .rd_sel       (rd_sel),
    .rd_count     (rd_count),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode: 0 random, 1 rate sort, 2 ch1+ch6 always, 3 ch0 always, 4 silent
  task automatic run_window(input int wl, input int mode, input int gap_at,
                            input int gap_len, input int hold_cycles);
    int eff, seen, last_c, cyc, mx, wi, nmax;
    int dens[N_CH];
    logic [N_CH-1:0] sp;
    logic en;
    logic [IDX_W-1:0] w_hold;
    logic [CNT_W-1:0] c_hold;
    logic t_hold;
    for (int i = 0; i < N_CH; i++) begin
      dens[i] = $urandom_range(0, 100);
      model_cnt[i] = 0;
    end
    eff = (wl == 0) ? 1 : wl;
    seen = 0;
    last_c = -1;
    result_ready = 1'b0;
    win_len = WIN_W'(wl);
    start = 1'b1;
    step();
    start = 1'b0;
    win_len = WIN_W'($urandom);
    check("busy_after_start", busy, 1);
    cyc = 1;
    while (!result_valid && cyc < 4000) begin
      sp = '0;
      en = 1'b1;
      case (mode)
        0: begin
          for (int i = 0; i < N_CH; i++) sp[i] = ($urandom_range(0, 99) < dens[i]);
          en = ($urandom_range(0, 3) != 0);
        end
        1: begin sp[3] = 1'b1; sp[5] = (cyc % 2 == 0); end
        2: begin sp[1] = 1'b1; sp[6] = 1'b1; end
        3: sp[0] = 1'b1;
        default: sp = '0;
      endcase
      if (cyc >= gap_at && cyc < gap_at + gap_len) en = 1'b0;
      spike_in = sp;
      ena = en;
      if (en && seen < eff) begin
        for (int i = 0; i < N_CH; i++)
          if (sp[i]) model_cnt[i] = (model_cnt[i] < SAT) ? model_cnt[i] + 1 : SAT;
        seen++;
        if (seen == eff) last_c = cyc;
      end
      step();
      cyc++;
    end
    check("valid_cycle", cyc, last_c + N_CH + 1);

    mx = 0;
    for (int i = 0; i < N_CH; i++) if (model_cnt[i] > mx) mx = model_cnt[i];
    wi = -1;
    nmax = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (model_cnt[i] == mx) begin
        nmax++;
        if (wi < 0) wi = i;
      end
    end
    check("winner", winner, wi);
    check("winner_count", winner_count, mx);
    check("tie", tie, (nmax > 1) ? 1 : 0);

    // scoreboard: expected tallies, read back through rd_sel while in HOLD
    for (int i = 0; i < N_CH; i++) exp_q.push_back(CNT_W'(model_cnt[i]));
    for (int i = 0; i < N_CH; i++) begin
      rd_sel = IDX_W'(i);
      step();
      check("rd_count", rd_count, exp_q.pop_front());
    end

    w_hold = winner;
    c_hold = winner_count;
    t_hold = tie;
    for (int k = 0; k < hold_cycles; k++) begin
      start = (k == 1);
      win_len = WIN_W'(5);
      step();
      check("hold_valid", result_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_winner", {winner, winner_count, tie}, {w_hold, c_hold, t_hold});
    end

    result_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    result_ready = 1'b0;
    check("valid_drop", result_valid, 0);
    check("idle_busy", busy, 0);
    rd_sel = IDX_W'(wi);
    #1;
    check("rd_after_accept", rd_count, mx);
    step();
    check("start_ignored", busy, 0);
  endtask

  task automatic reset_mid_accum();
    result_ready = 1'b0;
    win_len = WIN_W'(50);
    start = 1'b1;
    step();
    start = 1'b0;
    ena = 1'b1;
    spike_in = '1;
    for (int c = 1; c < 4; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    for (int i = 0; i < N_CH; i++) begin
      rd_sel = IDX_W'(i);
      #1;
      check("rst_rd_count", rd_count, 0);
    end
    for (int c = 0; c < 60; c++) step();
    check("rst_no_result", {busy, result_valid}, 0);
    spike_in = '0;
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    start = 1'b0;
    spike_in = '0;
    win_len = '0;
    result_ready = 1'b0;
    rd_sel = '0;
    repeat (3) step();
    check("reset_busy", busy, 0);
    check("reset_valid", result_valid, 0);
    check("reset_result", {winner, winner_count, tie}, 0);
    check("reset_rd_count", rd_count, 0);
    rst = 1'b0;
    step();

    run_window(20, 1, 0, 0, 7);
    run_window(300, 2, 0, 0, 3);
    run_window(10, 3, 4, 5, 2);
    run_window(0, 4, 0, 0, 7);
    for (int t = 0; t < 8; t++) begin
      run_window(($urandom_range(0, 3) == 0) ? $urandom_range(250, 300) : $urandom_range(0, 40),
                 0, $urandom_range(1, 20), $urandom_range(0, 6), $urandom_range(0, 4));
    end
    reset_mid_accum();
    run_window(12, 0, 3, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
